operand_sequencer: RTL

- Sits directly downstream of the push-button debouncer and upstream of the FFT butterfly core.
- Turns each clean button press into a step of a small operator sequence.
- Step 1: latch six signed operands (A, B and twiddle W, each as real and imaginary) from the board switches.
- Step 2: pulse start to the butterfly and wait for its done.
- Step 3: step a result-select index through the four butterfly outputs on each further press, for display.

---
 rtl/fft_io_pkg.sv | 20 ++
 rtl/rise_edge.sv | 25 ++
 rtl/operand_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/fft_io_pkg.sv
// rtl/fft_io_pkg.sv - shared sequencer state, operand and result index definitions
package fft_io_pkg;

  typedef enum logic [1:0] {LOAD, START, WAIT, SHOW} seq_state_t;

  localparam int NUM_OPERANDS = 6;

  localparam logic [2:0] OP_A_RE = 3'd0;
  localparam logic [2:0] OP_A_IM = 3'd1;
  localparam logic [2:0] OP_B_RE = 3'd2;
  localparam logic [2:0] OP_B_IM = 3'd3;
  localparam logic [2:0] OP_W_RE = 3'd4;
  localparam logic [2:0] OP_W_IM = 3'd5;

  localparam logic [1:0] RES_X_RE = 2'd0;
  localparam logic [1:0] RES_X_IM = 2'd1;
  localparam logic [1:0] RES_Y_RE = 2'd2;
  localparam logic [1:0] RES_Y_IM = 2'd3;

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - one-cycle pulse on each rising edge of a debounced button level
module rise_edge (
  input  logic clk,
  input  logic nReset,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic armed;

  // armed stays low until the level is seen low, so a button held through reset release is not a press
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (!level) armed <= 1'b1;
    end
  end

  assign pulse = level & ~level_q & armed;

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - button-driven operand entry, butterfly launch and result walk
module operand_sequencer
  import fft_io_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              btn,
  input  logic [DATA_W-1:0] sw,
  input  logic              done,
  output logic [DATA_W-1:0] a_re,
  output logic [DATA_W-1:0] a_im,
  output logic [DATA_W-1:0] b_re,
  output logic [DATA_W-1:0] b_im,
  output logic [DATA_W-1:0] w_re,
  output logic [DATA_W-1:0] w_im,
  output logic              start,
  output logic              busy,
  output logic [2:0]        load_idx,
  output logic [1:0]        res_sel,
  output logic              show,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT) + 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [DATA_W-1:0] ops [NUM_OPERANDS];
  logic [CNT_W-1:0]  cnt;
  logic              press;
  logic              expire;

  rise_edge u_rise_edge (
    .clk    (clk),
    .nReset (nReset),
    .level  (btn),
    .pulse  (press)
  );

  assign expire = (cnt == CNT_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (press && load_idx == OP_W_IM) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done || expire) state_nxt = SHOW;
      SHOW:    if (press && res_sel == RES_Y_IM) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NUM_OPERANDS; i++) ops[i] <= '0;
      load_idx    <= OP_A_RE;
      res_sel     <= RES_X_RE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (press) begin
            ops[load_idx] <= sw;
            load_idx      <= (load_idx == OP_W_IM) ? OP_A_RE : load_idx + 3'd1;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          // done takes priority over an expiry landing in the same cycle
          if (done)        res_sel     <= RES_X_RE;
          else if (expire) timeout_err <= 1'b1;
          else             cnt         <= cnt + 1'b1;
        end
        SHOW: begin
          if (press) begin
            if (res_sel == RES_Y_IM) begin
              res_sel     <= RES_X_RE;
              load_idx    <= OP_A_RE;
              timeout_err <= 1'b0;
            end else begin
              res_sel <= res_sel + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign start = (state == START);
  assign busy  = (state == START) || (state == WAIT);
  assign show  = (state == SHOW);

  assign a_re = ops[OP_A_RE];
  assign a_im = ops[OP_A_IM];
  assign b_re = ops[OP_B_RE];
  assign b_im = ops[OP_B_IM];
  assign w_re = ops[OP_W_RE];
  assign w_im = ops[OP_W_IM];

endmodule
